ghost_mode_scheduler: RTL
=========================

Name: ghost_mode_scheduler

Overview:
Global ghost-mode sequencer that sits directly upstream of the per-ghost controllers. It produces the shared mode word (SCATTER / CHASE / FRIGHTENED) from the classic scatter/chase phase table, overlaid with a power-pellet FRIGHTENED window. It also produces staggered per-ghost release (reload) pulses at the start of each round. All timing is counted in game ticks (i_tick), not clock cycles.

Parameters:
N_GHOST, 4, number of ghosts; width of the release vector
CNT_W, 12, width of the phase, frightened and release counters
P_SCAT_LONG, 420, ticks for scatter phases 0 and 2
P_SCAT_SHORT, 300, ticks for scatter phases 4 and 6
P_CHASE, 1200, ticks for chase phases 1, 3 and 5
P_FRIGHT, 360, frightened duration in ticks
P_FLASH, 120, final frightened ticks during which the flash output is high
P_REL_GAP, 120, ticks between successive ghost releases

Ports:
i_clk  in  1  clock
i_rst_n  in  1  async active-low reset
i_game_state  in  8  global game state (GS_* encodings)
i_tick  in  1  one-cycle game-tick strobe
i_power_pellet  in  1  one-cycle pulse when Pac-Man eats a power pellet
o_ghost_state  out  4  shared mode: SCATTER, CHASE or FRIGHTENED (params.vh encodings)
o_ghost_reload  out  N_GHOST  one-cycle release pulse per ghost
o_fright_flash  out  1  high during the last P_FLASH ticks of frightened
o_phase_idx  out  3  current scatter/chase phase index, 0..7

Behaviour:
- Clock and reset: i_clk; reset i_rst_n, asynchronous, active-low. All state is in a single clock domain.
- Reset values: o_ghost_state=SCATTER, o_ghost_reload=0, o_fright_flash=0, o_phase_idx=0, all counters 0, FSM in S_WAIT.
- Phase table:
  - even index = scatter, odd index = chase.
  - Durations: 0:P_SCAT_LONG, 1:P_CHASE, 2:P_SCAT_LONG, 3:P_CHASE, 4:P_SCAT_SHORT, 5:P_CHASE, 6:P_SCAT_SHORT, 7:chase, never expires.
- FSM states:
  - S_WAIT: entered whenever i_game_state is not one of GS_PLAY, GS_PAUSE, GS_IDLE or GS_RELOAD. Phase index = 0, phase counter = 0, frightened cleared, o_ghost_state=SCATTER, no release pulses.
  - S_PHASE: active when i_game_state==GS_PLAY. On i_tick the phase counter increments. When counter+1 equals the phase duration (and idx<7):
    - idx advances and the counter clears;
    - o_ghost_state updates on the cycle after that tick (1-cycle latency).
  - S_FRIGHT: phase counter frozen; fright counter decrements on i_tick. At 0, return to S_PHASE with the mode of the current idx; o_ghost_state updates on the cycle after the expiring tick.
- Power pellet: i_power_pellet in GS_PLAY loads fright counter = P_FRIGHT and enters S_FRIGHT; o_ghost_state=FRIGHTENED on the next cycle.
  - A pellet while already in S_FRIGHT reloads the counter and clears flash.
  - A pellet outside GS_PLAY is ignored.
- Flash: o_fright_flash = (state==S_FRIGHT) && (fright counter <= P_FLASH); registered.
- GS_PAUSE and GS_IDLE: all counters frozen, outputs held.
- GS_RELOAD (life lost): phase index and counters cleared, frightened cancelled, o_ghost_state=SCATTER, release schedule re-armed.
- Release schedule:
  - Armed on entry to GS_PLAY from S_WAIT or GS_RELOAD; the release counter starts at 0.
  - On each i_tick in GS_PLAY, bit k of o_ghost_reload pulses for exactly one cycle when the release counter == k*P_REL_GAP. The counter then increments.
  - The counter saturates after the last ghost is released; no further pulses until re-armed.
  - Release counting continues during S_FRIGHT.
- Simultaneous events:
  - Phase expiry and pellet on the same cycle: idx advances AND frightened is entered; the new phase mode is resumed after frightened ends.
  - Pellet and fright expiry on the same cycle: the pellet wins (reload, stay frightened).
  - Game state leaving PLAY/PAUSE/IDLE/RELOAD has priority over all other events.
- Width rules: counters are CNT_W unsigned and never wrap. The phase counter is held at 0 in phase 7, and the release counter saturates.
- Reset mid-operation: immediate return to the reset values; no pulse is emitted on reset release.

Decomposition:
- params.vh / shared package: SCATTER, CHASE, FRIGHTENED and the GS_* encodings (already present). Add the phase-duration lookup function (idx -> ticks, parameterised) and the FSM state typedef {S_WAIT, S_PHASE, S_FRIGHT}.
- One sub-module: ghost_release_timer. It takes i_clk, i_rst_n, arm, i_tick and enable, and outputs the N_GHOST one-cycle pulse vector.

Test Plan:
All scenarios use sim parameters P_SCAT_LONG=7, P_SCAT_SHORT=5, P_CHASE=20, P_FRIGHT=6, P_FLASH=2, P_REL_GAP=3, with i_tick every 4 clocks.
1. Reset, then GS_PLAY -> o_ghost_state=SCATTER. After the 7th tick -> CHASE, idx=1. After 20 more ticks -> SCATTER, idx=2. Full run reaches idx=7, and CHASE holds for 100+ ticks.
2. Pellet at tick 3 of phase 1 -> FRIGHTENED next cycle. o_fright_flash rises after the 4th frightened tick. After 6 ticks -> CHASE resumes, and the phase expires 17 ticks later.
3. Second pellet at frightened tick 5 -> counter reloads, flash drops, FRIGHTENED lasts 6 more ticks.
4. Entry to GS_PLAY -> o_ghost_reload bits 0,1,2,3 pulse once each, on ticks 1, 4, 7 and 10, each exactly 1 cycle wide. No further pulses follow.
5. GS_PAUSE for 50 ticks mid-chase, then GS_PLAY -> idx and remaining duration unchanged. GS_RELOAD -> idx=0, SCATTER, release re-armed. GS_GAMEOVER -> S_WAIT, SCATTER, pellet ignored.
6. Phase expiry and pellet on the same cycle in phase 0 -> FRIGHTENED with idx=1; CHASE after frightened ends. Async reset asserted mid-frightened -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/ghost_mode_scheduler_pkg.sv
// Shared encodings for the ghost-mode sequencer: mode words, game states,
// scheduler FSM states and the scatter/chase phase-duration table.
package ghost_mode_scheduler_pkg;

    localparam logic [3:0] SCATTER    = 4'd0;
    localparam logic [3:0] CHASE      = 4'd1;
    localparam logic [3:0] FRIGHTENED = 4'd2;

    localparam logic [7:0] GS_ATTRACT  = 8'h00;
    localparam logic [7:0] GS_IDLE     = 8'h01;
    localparam logic [7:0] GS_PLAY     = 8'h02;
    localparam logic [7:0] GS_PAUSE    = 8'h03;
    localparam logic [7:0] GS_RELOAD   = 8'h04;
    localparam logic [7:0] GS_GAMEOVER = 8'h05;

    typedef enum logic [1:0] {
        S_WAIT   = 2'd0,
        S_PHASE  = 2'd1,
        S_FRIGHT = 2'd2
    } sched_state_e;

    // Phase 7 returns 0: the final chase never expires.
    function automatic int phase_dur(input logic [2:0] idx, input int scat_long,
                                     input int scat_short, input int chase);
        case (idx)
            3'd0, 3'd2: phase_dur = scat_long;
            3'd4, 3'd6: phase_dur = scat_short;
            3'd7:       phase_dur = 0;
            default:    phase_dur = chase;
        endcase
    endfunction

    function automatic logic [3:0] phase_mode(input logic [2:0] idx);
        phase_mode = idx[0] ? CHASE : SCATTER;
    endfunction

endpackage

// File: rtl/ghost_mode_scheduler_release.sv
// Staggered ghost release: after arming, bit k pulses on the game tick at
// which the release counter equals k*P_REL_GAP; the counter then saturates.
module ghost_release_timer
    import ghost_mode_scheduler_pkg::*;
#(
    parameter int N_GHOST   = 4,
    parameter int CNT_W     = 12,
    parameter int P_REL_GAP = 120
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_arm,
    input  logic               i_tick,
    input  logic               i_enable,
    output logic [N_GHOST-1:0] o_reload
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'((N_GHOST - 1) * P_REL_GAP);

    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_eff;
    logic [N_GHOST-1:0] pulse_q, pulse_d;

    always_comb begin
        cnt_eff = i_arm ? '0 : cnt_q;
        cnt_d   = cnt_eff;
        pulse_d = '0;
        // Counter stops one past the last release point, so no pulse can repeat.
        if (i_enable && i_tick && (cnt_eff <= LAST)) begin
            for (int k = 0; k < N_GHOST; k++) begin
                pulse_d[k] = (cnt_eff == CNT_W'(k * P_REL_GAP));
            end
            cnt_d = cnt_eff + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q   <= '0;
            pulse_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    assign o_reload = pulse_q;

endmodule

// File: rtl/ghost_mode_scheduler.sv
// Global ghost-mode sequencer: scatter/chase phase table with a power-pellet
// frightened overlay, plus staggered per-ghost release pulses each round.
module ghost_mode_scheduler
    import ghost_mode_scheduler_pkg::*;
#(
    parameter int N_GHOST      = 4,
    parameter int CNT_W        = 12,
    parameter int P_SCAT_LONG  = 420,
    parameter int P_SCAT_SHORT = 300,
    parameter int P_CHASE      = 1200,
    parameter int P_FRIGHT     = 360,
    parameter int P_FLASH      = 120,
    parameter int P_REL_GAP    = 120
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [7:0]         i_game_state,
    input  logic               i_tick,
    input  logic               i_power_pellet,
    output logic [3:0]         o_ghost_state,
    output logic [N_GHOST-1:0] o_ghost_reload,
    output logic               o_fright_flash,
    output logic [2:0]         o_phase_idx
);

    sched_state_e     st_q, st_d, st_eff;
    logic [2:0]       idx_q, idx_d;
    logic [CNT_W-1:0] pcnt_q, pcnt_d;
    logic [CNT_W-1:0] fcnt_q, fcnt_d;
    logic [3:0]       mode_q, mode_d;
    logic             flash_q, flash_d;
    logic             arm_pend_q, arm_pend_d;

    logic in_play, in_hold, in_reload, in_wait, arm;

    assign in_play   = (i_game_state == GS_PLAY);
    assign in_hold   = (i_game_state == GS_PAUSE) || (i_game_state == GS_IDLE);
    assign in_reload = (i_game_state == GS_RELOAD);
    assign in_wait   = !(in_play || in_hold || in_reload);
    assign arm       = in_play && arm_pend_q;

    always_comb begin
        st_d       = st_q;
        idx_d      = idx_q;
        pcnt_d     = pcnt_q;
        fcnt_d     = fcnt_q;
        mode_d     = mode_q;
        arm_pend_d = arm_pend_q;
        st_eff     = (st_q == S_WAIT) ? S_PHASE : st_q;

        if (in_wait || in_reload) begin
            st_d       = in_wait ? S_WAIT : S_PHASE;
            idx_d      = '0;
            pcnt_d     = '0;
            fcnt_d     = '0;
            mode_d     = SCATTER;
            arm_pend_d = 1'b1;
        end else if (in_play) begin
            if (arm) arm_pend_d = 1'b0;
            st_d = st_eff;
            if (st_eff == S_PHASE) begin
                if (i_tick && (idx_q != 3'd7)) begin
                    if (int'(pcnt_q) + 1 == phase_dur(idx_q, P_SCAT_LONG, P_SCAT_SHORT, P_CHASE)) begin
                        idx_d  = idx_q + 3'd1;
                        pcnt_d = '0;
                        mode_d = phase_mode(idx_q + 3'd1);
                    end else begin
                        pcnt_d = pcnt_q + CNT_W'(1);
                    end
                end
            end else if (i_tick) begin
                if (fcnt_q <= CNT_W'(1)) begin
                    fcnt_d = '0;
                    st_d   = S_PHASE;
                    mode_d = phase_mode(idx_q);
                end else begin
                    fcnt_d = fcnt_q - CNT_W'(1);
                end
            end
            // A pellet overrides a coinciding frightened expiry; phase advance above still stands.
            if (i_power_pellet) begin
                st_d   = S_FRIGHT;
                fcnt_d = CNT_W'(P_FRIGHT);
                mode_d = FRIGHTENED;
            end
        end

        flash_d = (st_d == S_FRIGHT) && (fcnt_d <= CNT_W'(P_FLASH));
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            st_q       <= S_WAIT;
            idx_q      <= '0;
            pcnt_q     <= '0;
            fcnt_q     <= '0;
            mode_q     <= SCATTER;
            flash_q    <= 1'b0;
            arm_pend_q <= 1'b1;
        end else begin
            st_q       <= st_d;
            idx_q      <= idx_d;
            pcnt_q     <= pcnt_d;
            fcnt_q     <= fcnt_d;
            mode_q     <= mode_d;
            flash_q    <= flash_d;
            arm_pend_q <= arm_pend_d;
        end
    end

    ghost_release_timer #(
        .N_GHOST  (N_GHOST),
        .CNT_W    (CNT_W),
        .P_REL_GAP(P_REL_GAP)
    ) u_release (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_arm   (arm),
        .i_tick  (i_tick),
        .i_enable(in_play),
        .o_reload(o_ghost_reload)
    );

    assign o_ghost_state  = mode_q;
    assign o_fright_flash = flash_q;
    assign o_phase_idx    = idx_q;

endmodule
